// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Brief    : Shared state encoding and constants for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [DEFAULT_WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ripple_borrow_subtractor_8.sv
// ============================================================================
// Module   : ripple_borrow_subtractor_8
// Brief    : 8-bit a - b - bi built from a chain of full-subtractor cells.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_borrow_subtractor_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bi,
  output logic [7:0] d,
  output logic       bo
);

  logic [8:0] w_borrow;

  assign w_borrow[0] = bi;

  generate
    for (genvar i = 0; i < 8; i++) begin : g_cell
      assign d[i]            = a[i] ^ b[i] ^ w_borrow[i];
      assign w_borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
    end
  endgenerate

  assign bo = w_borrow[8];

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider_8.sv
// ============================================================================
// Module   : seq_restoring_divider_8
// Brief    : Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider_8
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_zero;
  logic             w_last;
  logic [WIDTH:0]   w_s;
  logic [WIDTH-1:0] w_diff;
  logic             w_bo;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  // FIN behaves like IDLE for new requests so divisions can issue back-to-back.
  assign w_accept = start && ((r_state == IDLE) || (r_state == FIN));
  assign w_zero   = (divisor == '0);
  assign w_last   = (r_state == CALC) && (r_cnt == CNT_W'(WIDTH - 1));

  assign w_s = {r_rem, r_q[WIDTH-1]};

  ripple_borrow_subtractor_8 u_sub (
    .a  (w_s[WIDTH-1:0]),
    .b  (r_d),
    .bi (1'b0),
    .d  (w_diff),
    .bo (w_bo)
  );

  // A set top bit of S means S exceeds any 8-bit divisor, so never restore.
  assign w_borrow   = ~w_s[WIDTH] & w_bo;
  assign w_rem_next = w_borrow ? w_s[WIDTH-1:0] : w_diff;
  assign w_q_next   = {r_q[WIDTH-2:0], ~w_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = w_zero ? FIN : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) w_state_next = FIN;
      end
      FIN: begin
        done = 1'b1;
        if (start) w_state_next = w_zero ? FIN : CALC;
        else       w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_d   <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_accept && !w_zero) begin
      r_q   <= dividend;
      r_d   <= divisor;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (r_state == CALC) begin
      r_q   <= w_q_next;
      r_rem <= w_rem_next;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Results load on the edge entering FIN so they are valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept && w_zero) begin
      quotient    <= DBZ_QUOTIENT;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (w_last) begin
      quotient    <= w_q_next;
      remainder   <= w_rem_next;
      div_by_zero <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider_8.sv
// ============================================================================
// Module   : tb_seq_restoring_divider_8
// Brief    : Directed and random checks of the divider against a / and % model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider_8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_tests;
  int n_fail;

  logic [7:0] prev_q;
  logic [7:0] prev_r;
  logic       prev_z;

  seq_restoring_divider_8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a request for one cycle; returns in cycle T+1 of the accepted start.
  task automatic start_req(input logic [7:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Checks the busy window and the result; returns sampling the done cycle.
  // pulse_at > 0 injects a competing request in cycle T+pulse_at.
  task automatic wait_result(input logic [7:0] a, input logic [7:0] b, input int pulse_at);
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    exp_q = (b == 0) ? 8'hFF : a / b;
    exp_r = (b == 0) ? a : a % b;
    if (b != 0) begin
      for (int k = 1; k <= 8; k++) begin
        check("busy_window", busy, 1);
        check("no_done_while_busy", done, 0);
        check("q_hold_while_busy", quotient, prev_q);
        check("r_hold_while_busy", remainder, prev_r);
        if (k == pulse_at) begin
          start = 1'b1; dividend = 8'd77; divisor = 8'd3;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
      start = 1'b0;
    end
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("quotient", quotient, exp_q);
    check("remainder", remainder, exp_r);
    check("div_by_zero", div_by_zero, (b == 0));
    prev_q = exp_q;
    prev_r = exp_r;
    prev_z = (b == 0);
  endtask

  task automatic go_idle();
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
    check("q_hold_idle", quotient, prev_q);
    check("z_hold_idle", div_by_zero, prev_z);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    n_tests  = 0;
    n_fail   = 0;
    prev_q   = 0;
    prev_r   = 0;
    prev_z   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 0;
    divisor  = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    start_req(8'd100, 8'd7);   wait_result(8'd100, 8'd7, 0);   go_idle();
    start_req(8'd255, 8'd1);   wait_result(8'd255, 8'd1, 0);   go_idle();
    start_req(8'd5, 8'd9);     wait_result(8'd5, 8'd9, 0);     go_idle();
    start_req(8'd255, 8'd255); wait_result(8'd255, 8'd255, 0); go_idle();

    start_req(8'd200, 8'd0);   wait_result(8'd200, 8'd0, 0);   go_idle();
    start_req(8'd9, 8'd3);     wait_result(8'd9, 8'd3, 0);     go_idle();

    // Competing request mid-flight must be ignored.
    start_req(8'd50, 8'd5);    wait_result(8'd50, 8'd5, 4);    go_idle();

    // Back-to-back: second request issued during the FIN cycle.
    start_req(8'd128, 8'd16);  wait_result(8'd128, 8'd16, 0);
    start_req(8'd99, 8'd10);   wait_result(8'd99, 8'd10, 0);   go_idle();

    // Consecutive divide-by-zero requests give consecutive done pulses.
    start_req(8'd17, 8'd0);    wait_result(8'd17, 8'd0, 0);
    start_req(8'd33, 8'd0);    wait_result(8'd33, 8'd0, 0);    go_idle();

    // Reset in cycle T+5 aborts the division.
    start_req(8'd240, 8'd7);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    prev_q = 0; prev_r = 0; prev_z = 0;
    repeat (6) begin
      @(negedge clk);
      check("no_done_in_reset", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("no_done_after_abort", done, 0);
    start_req(8'd240, 8'd7);   wait_result(8'd240, 8'd7, 0);   go_idle();

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      start_req(ra, rb);
      wait_result(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
      if ($urandom_range(0, 1) == 0) go_idle();
    end
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_restoring_divider_8.md
Name: seq_restoring_divider_8

Overview:
Multi-cycle unsigned 8-bit divider for the 3-stage processor's execute stage. It is the inverse arithmetic path to the combinational 8-bit adder.
One restoring step per clock. Each step uses an 8-bit ripple-borrow subtractor. A start/busy/done handshake lets the pipeline stall while a division is in flight.

Parameters:
WIDTH, 8, operand/quotient/remainder width (only 8 is verified)
CNT_W, 4, iteration counter width (must hold WIDTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a division; sampled only when busy=0
dividend  input  WIDTH  numerator, captured on accepted start
divisor  input  WIDTH  denominator, captured on accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when results are valid
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  set with done when divisor was 0

Behaviour:
- One clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and internal registers cleared.
- Reset asserted mid-division aborts it immediately. No done pulse; outputs read 0 after reset.
- States: IDLE, CALC, FIN.
- IDLE, start=1, divisor!=0:
  - capture Q=dividend, D=divisor, R=0 (WIDTH+1 bits), cnt=0
  - go to CALC; busy=1 from the next cycle
- IDLE, start=1, divisor==0:
  - go to FIN
  - quotient=all-ones (8'hFF), remainder=dividend, div_by_zero=1
- CALC, one step per cycle:
  - S = {R[WIDTH-1:0], Q[WIDTH-1]}
  - diff = S - {1'b0,D}
  - if no borrow: R=diff, Q={Q[WIDTH-2:0],1}
  - else: R=S, Q={Q[WIDTH-2:0],0}
  - cnt++; after the step where cnt==WIDTH-1, go to FIN
- FIN (one cycle):
  - done=1, busy=0
  - quotient=Q, remainder=R[WIDTH-1:0]; div_by_zero=0 unless the zero path was taken
  - go to IDLE
- Latency, accepted start at edge T:
  - normal: busy high T+1..T+8, done high in cycle T+9
  - divide-by-zero: done at T+1, busy never asserts
- start while busy=1 is ignored; operands are not re-captured.
- start during the FIN cycle is accepted as from IDLE (back-to-back issue). The next done comes 9 cycles later.
- quotient, remainder and div_by_zero hold their values until the next done. They do not change while busy.
- done never asserts in two consecutive cycles except for back-to-back divide-by-zero requests.

Decomposition:
- Shared package (div_pkg): state encoding constants IDLE=2'd0, CALC=2'd1, FIN=2'd2; WIDTH default; DBZ_QUOTIENT = all-ones.
- One sub-module: ripple_borrow_subtractor_8
  - inputs a[7:0], b[7:0], bi
  - outputs d[7:0], bo
  - built from full-subtractor cells
- The 9th bit of the partial remainder is folded into the borrow decision:
  - borrow = ~S[8] & bo
  - result = {1'b0, d}

Test Plan:
- 100 / 7, start at T: busy T+1..T+8; done at T+9 with quotient=14, remainder=2, div_by_zero=0.
- 255 / 1: quotient=255, remainder=0. Then 5 / 9: quotient=0, remainder=5. Then 255 / 255: quotient=1, remainder=0.
- 200 / 0: done at T+1 with quotient=8'hFF, remainder=200, div_by_zero=1, busy stays 0. A following 9 / 3 gives quotient=3, remainder=0, div_by_zero=0.
- Start 50 / 5, pulse start with 77 / 3 at T+4: second request ignored; done at T+9 with quotient=10, remainder=0.
- Back-to-back: 128 / 16 then 99 / 10 issued in the FIN cycle: first result 8/0; second done 9 cycles later with 9/9.
- rst_n low at T+5 of 240 / 7: all outputs 0 immediately, no done pulse. After release, 240 / 7 gives quotient=34, remainder=2.
